// File: rtl/lottery_pkg.sv
// rtl/lottery_pkg.sv - shared types and default constants for the lottery draw path
package lottery_pkg;
   localparam logic [7:0] DEF_SEED      = 8'h89;
   localparam logic [7:0] DEF_TAPS      = 8'hF3;
   localparam int         DEF_MAX_VALUE = 73;

   typedef logic [7:0] num_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAW    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;
endpackage

// File: rtl/lottery_draw_ctrl_lfsr8.sv
// rtl/lottery_draw_ctrl_lfsr8.sv - free-running 8-bit Galois LFSR (module lfsr8) with seed load
module lfsr8
   import lottery_pkg::*;
#(
   parameter num_t TAPS = DEF_TAPS,
   parameter num_t SEED = DEF_SEED
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  num_t seed,
   output num_t q
);
   num_t q_d, q_q;

   // A zero seed would lock the register, so it is replaced by SEED.
   always_comb begin
      if (load) begin
         q_d = (seed == '0) ? SEED : seed;
      end else begin
         q_d = {q_q[6:0], 1'b0} ^ ({8{q_q[7]}} & {TAPS[7:1], 1'b1});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= SEED;
      else        q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/lottery_draw_ctrl.sv
// rtl/lottery_draw_ctrl.sv - draw sequencer: LFSR sampling, range/repeat filter, valid/ack output
// Optional duplicate rejection within a round: LOTTERY_NO_REPEAT_EN.
module lottery_draw_ctrl
   import lottery_pkg::*;
#(
   parameter int   NUM_DRAWS = 6,
   parameter int   MAX_VALUE = DEF_MAX_VALUE,
   parameter num_t SEED      = DEF_SEED,
   parameter num_t TAPS      = DEF_TAPS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       seed_load,
   input  logic [7:0] seed_in,
   input  logic       num_ack,
   output logic [7:0] num_out,
   output logic       num_valid,
   output logic [7:0] draw_idx,
   output logic       busy,
   output logic       done
);
   localparam num_t MAX_V    = num_t'(MAX_VALUE);
   localparam num_t LAST_IDX = num_t'(NUM_DRAWS - 1);

   state_e state_d, state_q;
   num_t   num_out_d, num_out_q;
   num_t   draw_cnt_d, draw_cnt_q;
   logic   num_valid_d, num_valid_q;
   num_t   lfsr;
   logic   idle, in_range, accept;

   assign idle = (state_q == ST_IDLE);

   lfsr8 #(.TAPS(TAPS), .SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (seed_load && idle),
      .seed  (seed_in),
      .q     (lfsr)
   );

   assign in_range = (lfsr != '0) && (lfsr <= MAX_V);

`ifdef LOTTERY_NO_REPEAT_EN
   logic [MAX_VALUE:0] used_d, used_q, hit_vec;

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i <= MAX_VALUE; i++) hit_vec[i] = (lfsr == num_t'(i));
   end

   assign accept = in_range && !(|(used_q & hit_vec));

   always_comb begin
      used_d = used_q;
      if (idle && start) begin
         used_d = '0;
      end else if ((state_q == ST_DRAW) && !abort && accept) begin
         used_d = used_q | hit_vec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) used_q <= '0;
      else        used_q <= used_d;
   end
`else
   assign accept = in_range;
`endif

   always_comb begin
      state_d     = state_q;
      num_out_d   = num_out_q;
      num_valid_d = num_valid_q;
      draw_cnt_d  = draw_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_DRAW;
               draw_cnt_d = '0;
            end
         end
         ST_DRAW: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (accept) begin
               num_out_d   = lfsr;
               num_valid_d = 1'b1;
               state_d     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            // abort wins over a simultaneous ack so a cancelled round never reports done
            if (abort) begin
               num_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (num_ack) begin
               num_valid_d = 1'b0;
               if (draw_cnt_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  draw_cnt_d = draw_cnt_q + 8'd1;
                  state_d    = ST_DRAW;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         num_out_q   <= '0;
         num_valid_q <= 1'b0;
         draw_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         num_out_q   <= num_out_d;
         num_valid_q <= num_valid_d;
         draw_cnt_q  <= draw_cnt_d;
      end
   end

   assign num_out   = num_out_q;
   assign num_valid = num_valid_q;
   assign draw_idx  = draw_cnt_q;
   assign busy      = (state_q == ST_DRAW) || (state_q == ST_PRESENT);
   assign done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_lottery_draw_ctrl.sv
// tb/tb_lottery_draw_ctrl.sv - scoreboard bench for lottery_draw_ctrl
module tb_lottery_draw_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort, seed_load, num_ack;
   logic [7:0] seed_in;
   logic [7:0] num_out, draw_idx;
   logic       num_valid, busy, done;

   logic       s_start, s_num_ack;
   logic [7:0] s_num_out, s_draw_idx;
   logic       s_num_valid, s_busy, s_done;
   logic       s_zero;
   logic [7:0] s_zero8;

   int total = 0;
   int bad   = 0;

   logic [7:0]   exp_q[$];
   logic [255:0] used_mask;
   logic [7:0]   m_lfsr;

   always #5 clk = ~clk;

   lottery_draw_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .seed_load(seed_load), .seed_in(seed_in), .num_ack(num_ack),
      .num_out(num_out), .num_valid(num_valid), .draw_idx(draw_idx),
      .busy(busy), .done(done)
   );

   // Primitive taps (x^8+x^4+x^3+x^2+1) so every value 1..3 is reachable.
   lottery_draw_ctrl #(.NUM_DRAWS(3), .MAX_VALUE(3), .SEED(8'h89), .TAPS(8'h1D)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_zero),
      .seed_load(s_zero), .seed_in(s_zero8), .num_ack(s_num_ack),
      .num_out(s_num_out), .num_valid(s_num_valid), .draw_idx(s_draw_idx),
      .busy(s_busy), .done(s_done)
   );

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic [7:0] taps;
      logic [7:0] r;
      taps = 8'hF3;
      r[0] = v[7];
      for (int i = 1; i < 8; i++) r[i] = v[i-1] ^ (taps[i] & v[7]);
      return r;
   endfunction

   function automatic logic [7:0] predict(input logic [7:0] v);
      logic [7:0] c;
      c = v;
      for (int n = 0; n < 600; n++) begin
`ifdef LOTTERY_NO_REPEAT_EN
         if (c >= 8'd1 && c <= 8'd73 && !used_mask[c]) return c;
`else
         if (c >= 8'd1 && c <= 8'd73) return c;
`endif
         c = lfsr_next(c);
      end
      return 8'h00;
   endfunction

   // Reference LFSR; seed_load is only driven while the main DUT is idle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         m_lfsr <= 8'h89;
      else if (seed_load) m_lfsr <= (seed_in == 8'h00) ? 8'h89 : seed_in;
      else                m_lfsr <= lfsr_next(m_lfsr);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1);
   end

   task automatic wait_valid(output bit ok);
      int n;
      n = 0;
      while (num_valid !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      ok = (num_valid === 1'b1);
      if (!ok) begin
         bad++;
         $display("FAIL wait_valid: num_valid=%b after %0d cycles, need 1", num_valid, n);
      end
   endtask

   task automatic sb_pop();
      logic [7:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL sb_empty: got num_out=%0d with no expected entry", num_out);
      end else begin
         e = exp_q.pop_front();
         used_mask[e] = 1'b1;
         if (num_out !== e) begin
            bad++;
            $display("FAIL sb_num_out: got %0d need %0d", num_out, e);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; abort = 0; seed_load = 0; num_ack = 0; seed_in = 8'h00;
      s_start = 0; s_num_ack = 0; s_zero = 0; s_zero8 = 8'h00;
      used_mask = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({num_out, num_valid, draw_idx, busy, done} !== 19'h0) begin
         bad++;
         $display("FAIL reset_outputs: out=%h v=%b idx=%h busy=%b done=%b need all 0",
                  num_out, num_valid, draw_idx, busy, done);
      end
      total++;
      if (dut.u_lfsr.q_q !== 8'h89) begin
         bad++;
         $display("FAIL reset_lfsr: got %h need 89", dut.u_lfsr.q_q);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_seed();
      seed_in = 8'h00; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      total++;
      if (dut.u_lfsr.q_q !== 8'h89) begin
         bad++;
         $display("FAIL zero_seed: lfsr=%h need 89", dut.u_lfsr.q_q);
      end
      @(negedge clk);
   endtask

   task automatic test_seed_latency();
      bit ok;
      seed_in = 8'h89; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      used_mask = '0;
      exp_q.push_back(predict(m_lfsr));
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL start_busy: busy=%b need 1", busy);
      end
      @(negedge clk);
      total++;
      if (num_valid !== 1'b0) begin
         bad++;
         $display("FAIL latency_early: num_valid=%b need 0", num_valid);
      end
      @(negedge clk);
      total++;
      if (num_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency_valid: num_valid=%b need 1", num_valid);
      end
      wait_valid(ok);
      if (!ok) return;
      sb_pop();
      total++;
      if (num_out !== 8'd49 || draw_idx !== 8'd0) begin
         bad++;
         $display("FAIL seed_first: num_out=%0d idx=%0d need 49 idx 0", num_out, draw_idx);
      end
   endtask

   task automatic test_hold_stable();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (num_valid !== 1'b1 || num_out !== 8'd49) begin
            bad++;
            $display("FAIL hold_stable: cycle %0d v=%b out=%0d need 1 and 49", i, num_valid, num_out);
         end
      end
   endtask

   task automatic test_abort();
      abort = 1'b1; num_ack = 1'b1;
      @(negedge clk);
      abort = 1'b0; num_ack = 1'b0;
      total++;
      if (num_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_ack: v=%b busy=%b done=%b need 0 0 0", num_valid, busy, done);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_no_done: done=%b busy=%b need 0 0", done, busy);
      end
   endtask

   task automatic test_ack_ignored();
      num_ack = 1'b1;
      @(negedge clk);
      num_ack = 1'b0;
      total++;
      if (busy !== 1'b0 || num_valid !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL ack_idle: busy=%b v=%b done=%b need 0 0 0", busy, num_valid, done);
      end
   endtask

   task automatic run_round(input bit poke_start);
      bit ok;
      logic [7:0] held;
      used_mask = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_q.push_back(predict(m_lfsr));
      for (int d = 0; d < 6; d++) begin
         wait_valid(ok);
         if (!ok) return;
         sb_pop();
         total++;
         if (draw_idx !== 8'(d)) begin
            bad++;
            $display("FAIL round_idx: got %0d need %0d", draw_idx, d);
         end
         total++;
         if (num_out == 8'd0 || num_out > 8'd73) begin
            bad++;
            $display("FAIL round_range: got %0d need 1..73", num_out);
         end
         if (poke_start && d == 1) begin
            held = num_out;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            total++;
            if (num_valid !== 1'b1 || num_out !== held || draw_idx !== 8'd1) begin
               bad++;
               $display("FAIL start_busy_ignored: v=%b out=%0d idx=%0d need 1 %0d 1",
                        num_valid, num_out, draw_idx, held);
            end
         end
         num_ack = 1'b1;
         @(negedge clk);
         num_ack = 1'b0;
         if (d < 5) begin
            total++;
            if (done !== 1'b0 || num_valid !== 1'b0 || busy !== 1'b1) begin
               bad++;
               $display("FAIL ack_next: done=%b v=%b busy=%b need 0 0 1", done, num_valid, busy);
            end
            exp_q.push_back(predict(m_lfsr));
         end else begin
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
               bad++;
               $display("FAIL done_pulse: done=%b busy=%b need 1 0", done, busy);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
               bad++;
               $display("FAIL done_single: done=%b need 0", done);
            end
         end
      end
   endtask

   task automatic test_full_round();
      run_round(1'b1);
   endtask

   task automatic test_back_to_back();
      run_round(1'b0);
   endtask

   task automatic test_reset_mid();
      bit ok;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(ok);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({num_out, num_valid, draw_idx, busy, done} !== 19'h0 || dut.u_lfsr.q_q !== 8'h89) begin
         bad++;
         $display("FAIL reset_mid: out=%h v=%b idx=%h busy=%b done=%b lfsr=%h need zeros and 89",
                  num_out, num_valid, draw_idx, busy, done, dut.u_lfsr.q_q);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_repeat();
      logic [3:0] seen;
      int n;
      seen = 4'b0000;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         n = 0;
         while (s_num_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         total++;
         if (s_num_valid !== 1'b1) begin
            bad++;
            $display("FAIL small_wait: s_num_valid=%b need 1", s_num_valid);
            return;
         end
         total++;
         if (s_num_out == 8'd0 || s_num_out > 8'd3) begin
            bad++;
            $display("FAIL small_range: got %0d need 1..3", s_num_out);
         end else begin
            seen[s_num_out[1:0]] = 1'b1;
         end
         s_num_ack = 1'b1;
         @(negedge clk);
         s_num_ack = 1'b0;
      end
      total++;
      if (s_done !== 1'b1) begin
         bad++;
         $display("FAIL small_done: s_done=%b need 1", s_done);
      end
`ifdef LOTTERY_NO_REPEAT_EN
      total++;
      if (seen !== 4'b1110) begin
         bad++;
         $display("FAIL small_perm: seen mask=%b need 1110", seen);
      end
`endif
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_zero_seed();
      test_seed_latency();
      test_hold_stable();
      test_abort();
      test_ack_ignored();
      test_full_round();
      test_back_to_back();
      test_reset_mid();
      test_no_repeat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
